lane_dispatcher: RTL
====================

# lane_dispatcher

Parametrised round-robin dispatcher that splits one input block stream across NUM_LANES processing lanes, tagging each block with a wrapping sequence ID. Each lane has its own LANE_FIFO_DEPTH-deep buffer with full valid/ready semantics, so lane back-pressure never drops or duplicates data. A run-time mode selects strict round-robin or skip-full (work-conserving) lane selection. It sits between the block input stream and the parallel lane engines; downstream reordering uses the sequence IDs.

## Interface
- BLOCK_WIDTH, 32, data bits per block
- NUM_LANES, 4, number of output lanes; ≥2, any integer, power of two not required
- SEQUENCE_ID_WIDTH, 8, sequence tag width; tag wraps modulo 2^SEQUENCE_ID_WIDTH
- LANE_FIFO_DEPTH, 4, entries per lane buffer; power of two, ≥2
- clk  in  1  clock; one clock domain; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- mode  in  1  0 = strict round-robin, 1 = skip-full
- data_in  in  BLOCK_WIDTH  input block
- data_in_valid  in  1  input block valid
- data_in_ready  out  1  dispatcher accepts data_in this cycle
- lane_data  out  [BLOCK_WIDTH-1:0] x NUM_LANES (unpacked)  head block of each lane buffer
- lane_seq_id  out  [SEQUENCE_ID_WIDTH-1:0] x NUM_LANES (unpacked)  sequence tag of head block
- lane_valid  out  1 x NUM_LANES (unpacked)  lane buffer non-empty
- lane_ready  in  1 x NUM_LANES (unpacked)  lane consumes head block
- lane_count  out  [$clog2(LANE_FIFO_DEPTH+1)-1:0] x NUM_LANES (unpacked)  current occupancy per lane

## Operation
- State: rr_ptr (0..NUM_LANES-1), seq_counter, and per lane a circular buffer (storage, write/read pointers, occupancy count).
- Target lane selection, each cycle, from registered state plus mode:
  - mode 0: target = rr_ptr; data_in_ready = (count[rr_ptr] != LANE_FIFO_DEPTH).
  - mode 1: target = first lane, scanning cyclically from rr_ptr, with count != LANE_FIFO_DEPTH; data_in_ready = 1 if any such lane exists, else 0.
- Accept = data_in_valid && data_in_ready: push {data_in, seq_counter} into target lane; seq_counter += 1 (wraps 2^W−1 → 0); rr_ptr = target+1, wrapping NUM_LANES−1 → 0 (explicit compare, not bit truncation).
- No accept: rr_ptr and seq_counter hold.
- Pop = lane_valid[i] && lane_ready[i]: head advances, count decrements.
- Push and pop to the same lane in one cycle: count unchanged, both take effect.
- Full lane with simultaneous pop is still treated as full for that cycle (ready uses registered count only).
- lane_valid[i] = (count[i] != 0). lane_data[i] and lane_seq_id[i] are the head entry when lane_valid[i] = 1; driven to 0 when lane_valid[i] = 0.
- Mode change takes effect on the next selection; buffered blocks are never reordered within a lane.
- lane_ready[i] is ignored when lane_valid[i] = 0.

## Timing
- Reset (rst_n = 0 at a rising edge): all buffers empty, counts 0, rr_ptr 0, seq_counter 0. The following cycle: lane_valid all 0, lane_data/lane_seq_id all 0, lane_count all 0, data_in_ready = 1. Storage contents need not be reset.
- Reset mid-operation discards all buffered blocks; no pops are reported after the reset edge.
- Latency: block accepted at edge N is visible at the lane head after edge N (lane_valid high in cycle N+1) if that lane was empty.
- Throughput: one block accepted per cycle; each lane drains one block per cycle.
- data_in_ready is a function of registered counts, rr_ptr and mode only; no combinational path from lane_ready or data_in_valid to data_in_ready.
- lane_valid, lane_count depend on registered state only.

## Test plan
- Mode 0, all lane_ready=1, stream 8 blocks 0xA0..0xA7 → lane0 gets 0xA0/seq0 then 0xA4/seq4, lane3 gets 0xA3/seq3 then 0xA7/seq7; each visible one cycle after accept; no stall.
- Mode 0, all lane_ready=0, stream 20 blocks → 16 accepted, all lane_count=4, data_in_ready=0 with rr_ptr=0; pulse lane_ready[0] one cycle → lane0 emits seq0, next cycle data_in_ready=1 and block 16 lands in lane0 with seq 16.
- Lane1 full (count 4), others empty, rr_ptr=1, all lane_ready=0: mode 0 → data_in_ready=0; switch mode=1 → next block goes to lane2, rr_ptr becomes 3.
- 258 blocks with all lanes draining → block 255 tagged 0xFF, block 256 tagged 0x00, block 257 tagged 0x01.
- NUM_LANES=3, LANE_FIFO_DEPTH=2, mode 0 → lanes selected 0,1,2,0,1,2; simultaneous push/pop on a count-1 lane keeps count 1.
- Lanes partially filled, assert rst_n=0 one cycle → next cycle all lane_valid=0, lane_count=0, data_in_ready=1; first block afterwards goes to lane0 with seq0.

Source files
------------

// File: rtl/lane_dispatcher.sv
// Round-robin block dispatcher: spreads one input stream over NUM_LANES
// buffered lanes and tags every accepted block with a wrapping sequence ID.
module lane_dispatcher #(
  parameter int unsigned BLOCK_WIDTH       = 32,
  parameter int unsigned NUM_LANES         = 4,
  parameter int unsigned SEQUENCE_ID_WIDTH = 8,
  parameter int unsigned LANE_FIFO_DEPTH   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      mode,
  input  logic [BLOCK_WIDTH-1:0]                    data_in,
  input  logic                                      data_in_valid,
  output logic                                      data_in_ready,
  output logic [BLOCK_WIDTH-1:0]                    lane_data   [NUM_LANES],
  output logic [SEQUENCE_ID_WIDTH-1:0]              lane_seq_id [NUM_LANES],
  output logic                                      lane_valid  [NUM_LANES],
  input  logic                                      lane_ready  [NUM_LANES],
  output logic [$clog2(LANE_FIFO_DEPTH+1)-1:0]      lane_count  [NUM_LANES]
);

  localparam int unsigned LW = $clog2(NUM_LANES);
  localparam int unsigned AW = $clog2(LANE_FIFO_DEPTH);
  localparam int unsigned CW = $clog2(LANE_FIFO_DEPTH + 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(NUM_LANES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(LANE_FIFO_DEPTH);

  typedef struct packed {
    logic [BLOCK_WIDTH-1:0]       data;
    logic [SEQUENCE_ID_WIDTH-1:0] seq;
  } entry_t;

  logic [LW-1:0]                rr_ptr;
  logic [LW-1:0]                target;
  logic [SEQUENCE_ID_WIDTH-1:0] seq_counter;
  logic                         accept;
  logic [NUM_LANES-1:0]         lane_full;
  logic [NUM_LANES-1:0]         push;
  logic [NUM_LANES-1:0]         pop;

  entry_t        mem    [NUM_LANES][LANE_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [NUM_LANES];
  logic [AW-1:0] rd_ptr [NUM_LANES];
  logic [CW-1:0] count  [NUM_LANES];

  // Lane index k steps after base, wrapping at NUM_LANES (works for any lane count)
  function automatic logic [LW-1:0] lane_offset(input logic [LW-1:0] base, input int unsigned k);
    int unsigned sum;
    sum = 32'(base) + k;
    if (sum >= NUM_LANES) sum = sum - NUM_LANES;
    return LW'(sum);
  endfunction

  // Target lane and input ready from registered occupancy, rr_ptr and mode only
  always_comb begin
    target        = rr_ptr;
    data_in_ready = 1'b0;
    if (!mode) begin
      data_in_ready = !lane_full[rr_ptr];
    end else begin
      // Scan backwards so the last hit is the first free lane from rr_ptr
      for (int k = int'(NUM_LANES) - 1; k >= 0; k--) begin
        if (!lane_full[lane_offset(rr_ptr, 32'(k))]) begin
          target        = lane_offset(rr_ptr, 32'(k));
          data_in_ready = 1'b1;
        end
      end
    end
  end

  assign accept = data_in_valid && data_in_ready;

  // Round-robin pointer and sequence tag advance only on an accepted block
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      seq_counter <= '0;
    end else if (accept) begin
      rr_ptr      <= (target == LAST_LANE) ? '0 : target + LW'(1);
      seq_counter <= seq_counter + SEQUENCE_ID_WIDTH'(1);
    end
  end

  // Lane storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {data_in, seq_counter};
    end
  end

  for (genvar gi = 0; gi < int'(NUM_LANES); gi++) begin : g_lane
    entry_t head;

    // Per-lane full/push/pop decode
    always_comb begin
      lane_full[gi] = (count[gi] == FULL_COUNT);
      push[gi]      = accept && (target == LW'(gi));
      pop[gi]       = (count[gi] != '0) && lane_ready[gi];
    end

    // Circular buffer pointers and occupancy
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr[gi] <= '0;
        rd_ptr[gi] <= '0;
        count[gi]  <= '0;
      end else begin
        if (push[gi]) wr_ptr[gi] <= wr_ptr[gi] + AW'(1);
        if (pop[gi])  rd_ptr[gi] <= rd_ptr[gi] + AW'(1);
        case ({push[gi], pop[gi]})
          2'b10:   count[gi] <= count[gi] + CW'(1);
          2'b01:   count[gi] <= count[gi] - CW'(1);
          default: count[gi] <= count[gi];
        endcase
      end
    end

    // Head presentation, zeroed while the lane is empty
    always_comb begin
      head            = mem[gi][rd_ptr[gi]];
      lane_valid[gi]  = (count[gi] != '0);
      lane_count[gi]  = count[gi];
      lane_data[gi]   = lane_valid[gi] ? head.data : '0;
      lane_seq_id[gi] = lane_valid[gi] ? head.seq  : '0;
    end
  end

endmodule
